// File: rtl/ahbl_arb_2to1.sv
// ---------------------------------------------------------------------------
// ahbl_arb_2to1
//
// Two-hart AHB-Lite arbiter.  It merges two upstream AHB-Lite masters (s0, s1)
// onto one downstream AHB-Lite port (m).
//
// Ports
//   clk, rst_n                  clock and asynchronous active-low reset
//   s{0,1}_haddr .. s{0,1}_hexcl  upstream address phase (inputs)
//   s{0,1}_hwdata               upstream write data (input)
//   s{0,1}_hready/hresp/hexokay upstream response (outputs)
//   s{0,1}_hrdata               upstream read data (output)
//   m_haddr .. m_hexcl          downstream address phase (outputs)
//   m_hwdata                    downstream write data (output)
//   m_hready/hresp/hexokay      downstream response (inputs)
//   m_hrdata                    downstream read data (input)
//   m_hmaster                   index of the port owning the current
//                               downstream address phase
//
// Handshake: an upstream port presents a transfer when sn_htrans[1]=1 while
// the arbiter drives sn_hready=1; from the master's point of view that address
// phase is then accepted.  The arbiter either forwards it downstream in the
// same cycle (m_hready=1 and granted) or captures it into the port's buffer
// and holds sn_hready=0 until the buffered copy has been issued.  Downstream,
// a transfer is accepted when m_htrans=NONSEQ and m_hready=1 in one cycle.
// ---------------------------------------------------------------------------
module ahbl_arb_2to1 #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream port 0
  input  logic [W_ADDR-1:0] s0_haddr,
  input  logic              s0_hwrite,
  input  logic [1:0]        s0_htrans,
  input  logic [2:0]        s0_hsize,
  input  logic [2:0]        s0_hburst,
  input  logic [3:0]        s0_hprot,
  input  logic              s0_hmastlock,
  input  logic              s0_hexcl,
  input  logic [W_DATA-1:0] s0_hwdata,
  output logic              s0_hready,
  output logic              s0_hresp,
  output logic              s0_hexokay,
  output logic [W_DATA-1:0] s0_hrdata,
  // upstream port 1
  input  logic [W_ADDR-1:0] s1_haddr,
  input  logic              s1_hwrite,
  input  logic [1:0]        s1_htrans,
  input  logic [2:0]        s1_hsize,
  input  logic [2:0]        s1_hburst,
  input  logic [3:0]        s1_hprot,
  input  logic              s1_hmastlock,
  input  logic              s1_hexcl,
  input  logic [W_DATA-1:0] s1_hwdata,
  output logic              s1_hready,
  output logic              s1_hresp,
  output logic              s1_hexokay,
  output logic [W_DATA-1:0] s1_hrdata,
  // downstream port
  output logic [W_ADDR-1:0] m_haddr,
  output logic              m_hwrite,
  output logic [1:0]        m_htrans,
  output logic [2:0]        m_hsize,
  output logic [2:0]        m_hburst,
  output logic [3:0]        m_hprot,
  output logic              m_hmastlock,
  output logic              m_hexcl,
  output logic [W_DATA-1:0] m_hwdata,
  input  logic              m_hready,
  input  logic              m_hresp,
  input  logic              m_hexokay,
  input  logic [W_DATA-1:0] m_hrdata,
  output logic              m_hmaster
);

  localparam logic [1:0] HTRANS_IDLE    = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;

  // Address-phase fields carried through the arbiter.  htrans and hburst are
  // not stored: every issued transfer is re-encoded as a single NONSEQ.
  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [3:0]        prot;
    logic              lock;
    logic              excl;
  } req_t;

  req_t       w_live_req [2];
  req_t       w_cand_req [2];
  req_t       w_sel;
  logic [1:0] w_sready;
  logic [1:0] w_live;
  logic [1:0] w_cand;
  logic [1:0] w_take;
  logic       w_issue;
  logic       w_gnt;
  logic       w_out;
  logic       w_unused;

  req_t       r_buf [2];
  logic [1:0] r_buf_vld;
  logic       r_own_vld;   // a data phase is in flight
  logic       r_own;       // port owning that data phase
  logic       r_last;      // last granted port (round-robin pointer)
  logic       r_locked;    // grant pinned by hmastlock
  logic       r_lock_port;
  req_t       r_held;      // last issued address phase, shown while idle
  logic       r_held_mst;

  assign w_unused = ^{s0_htrans[0], s0_hburst, s1_htrans[0], s1_hburst};

  assign w_live_req[0] = '{addr: s0_haddr, write: s0_hwrite, size: s0_hsize,
                           prot: s0_hprot, lock: s0_hmastlock, excl: s0_hexcl};
  assign w_live_req[1] = '{addr: s1_haddr, write: s1_hwrite, size: s1_hsize,
                           prot: s1_hprot, lock: s1_hmastlock, excl: s1_hexcl};

  // A buffered port is stalled; the data-phase owner follows m_hready;
  // an idle bystander is always ready.
  assign w_sready[0] = r_buf_vld[0] ? 1'b0 : ((r_own_vld && !r_own) ? m_hready : 1'b1);
  assign w_sready[1] = r_buf_vld[1] ? 1'b0 : ((r_own_vld &&  r_own) ? m_hready : 1'b1);

  assign w_live[0] = s0_htrans[1] & w_sready[0];
  assign w_live[1] = s1_htrans[1] & w_sready[1];

  // Buffer and live request of one port are mutually exclusive (buffered
  // port sees hready=0), so buffered-first selection is unambiguous.
  assign w_cand[0]     = r_buf_vld[0] | w_live[0];
  assign w_cand[1]     = r_buf_vld[1] | w_live[1];
  assign w_cand_req[0] = r_buf_vld[0] ? r_buf[0] : w_live_req[0];
  assign w_cand_req[1] = r_buf_vld[1] ? r_buf[1] : w_live_req[1];

  always_comb begin
    w_issue = 1'b0;
    w_gnt   = 1'b0;
    if (m_hready) begin
      if (r_locked) begin
        // Locked sequence: only the lock owner may issue.  If it has nothing
        // this cycle an IDLE goes out and the lock drops.
        if (w_cand[r_lock_port]) begin
          w_issue = 1'b1;
          w_gnt   = r_lock_port;
        end
      end else if (w_cand[0] && w_cand[1]) begin
        w_issue = 1'b1;
        w_gnt   = ~r_last;
      end else if (w_cand[0]) begin
        w_issue = 1'b1;
        w_gnt   = 1'b0;
      end else if (w_cand[1]) begin
        w_issue = 1'b1;
        w_gnt   = 1'b1;
      end
    end
  end

  assign w_sel     = w_cand_req[w_gnt];
  assign w_take[0] = w_issue & ~w_gnt;
  assign w_take[1] = w_issue &  w_gnt;

  // rst_n gates only the outputs so the bus is IDLE for the whole reset
  // window even while upstream masters are already driving requests.
  assign w_out = w_issue & rst_n;

  assign m_htrans    = w_out ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign m_hburst    = 3'b000;
  assign m_haddr     = w_out ? w_sel.addr  : r_held.addr;
  assign m_hwrite    = w_out ? w_sel.write : r_held.write;
  assign m_hsize     = w_out ? w_sel.size  : r_held.size;
  assign m_hprot     = w_out ? w_sel.prot  : r_held.prot;
  assign m_hmastlock = w_out ? w_sel.lock  : r_held.lock;
  assign m_hexcl     = w_out ? w_sel.excl  : r_held.excl;
  assign m_hmaster   = w_out ? w_gnt       : r_held_mst;

  assign m_hwdata = r_own_vld ? (r_own ? s1_hwdata : s0_hwdata) : '0;

  assign s0_hready  = w_sready[0];
  assign s1_hready  = w_sready[1];
  assign s0_hresp   = r_own_vld && !r_own && m_hresp;
  assign s1_hresp   = r_own_vld &&  r_own && m_hresp;
  assign s0_hexokay = r_own_vld && !r_own && m_hexokay;
  assign s1_hexokay = r_own_vld &&  r_own && m_hexokay;
  assign s0_hrdata  = (r_own_vld && !r_own) ? m_hrdata : '0;
  assign s1_hrdata  = (r_own_vld &&  r_own) ? m_hrdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_buf_vld   <= 2'b00;
      r_own_vld   <= 1'b0;
      r_own       <= 1'b0;
      r_last      <= 1'b1;
      r_locked    <= 1'b0;
      r_lock_port <= 1'b0;
      r_held      <= '0;
      r_held_mst  <= 1'b0;
    end else begin
      // Any live request that is not forwarded this cycle has already been
      // accepted by its master, so it must be captured.
      for (int n = 0; n < 2; n++) begin
        if (w_take[n]) begin
          r_buf_vld[n] <= 1'b0;
        end else if (w_live[n]) begin
          r_buf_vld[n] <= 1'b1;
          r_buf[n]     <= w_live_req[n];
        end
      end
      if (m_hready) begin
        if (w_issue) begin
          r_own_vld   <= 1'b1;
          r_own       <= w_gnt;
          r_last      <= w_gnt;
          r_locked    <= w_sel.lock;
          r_lock_port <= w_gnt;
          r_held      <= w_sel;
          r_held_mst  <= w_gnt;
        end else begin
          r_own_vld <= 1'b0;
          r_locked  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arb_2to1.sv
// ---------------------------------------------------------------------------
// tb_ahbl_arb_2to1
//
// Directed bench for ahbl_arb_2to1.  Expected downstream transfers are pushed
// into exp_q in issue order when the stimulus is applied; a monitor pops one
// entry for every transfer the DUT puts on the downstream bus with
// m_hready=1.  Cycle-level response and hready behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_ahbl_arb_2to1;

  localparam int W  = 32;
  // {hmaster, haddr, hwrite, hmastlock, hexcl, hsize, htrans, hburst}
  localparam int IW = 1 + 32 + 1 + 1 + 1 + 3 + 2 + 3;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  s0_haddr, s1_haddr;
  logic          s0_hwrite, s1_hwrite;
  logic [1:0]    s0_htrans, s1_htrans;
  logic [2:0]    s0_hsize, s1_hsize;
  logic [2:0]    s0_hburst, s1_hburst;
  logic [3:0]    s0_hprot, s1_hprot;
  logic          s0_hmastlock, s1_hmastlock;
  logic          s0_hexcl, s1_hexcl;
  logic [W-1:0]  s0_hwdata, s1_hwdata;
  logic          s0_hready, s1_hready;
  logic          s0_hresp, s1_hresp;
  logic          s0_hexokay, s1_hexokay;
  logic [W-1:0]  s0_hrdata, s1_hrdata;
  logic [W-1:0]  m_haddr;
  logic          m_hwrite;
  logic [1:0]    m_htrans;
  logic [2:0]    m_hsize;
  logic [2:0]    m_hburst;
  logic [3:0]    m_hprot;
  logic          m_hmastlock;
  logic          m_hexcl;
  logic [W-1:0]  m_hwdata;
  logic          m_hready;
  logic          m_hresp;
  logic          m_hexokay;
  logic [W-1:0]  m_hrdata;
  logic          m_hmaster;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] mon_got;
  logic [IW-1:0] mon_exp;
  int            total;
  int            bad;

  ahbl_arb_2to1 #(.W_ADDR(W), .W_DATA(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_haddr(s0_haddr), .s0_hwrite(s0_hwrite), .s0_htrans(s0_htrans),
    .s0_hsize(s0_hsize), .s0_hburst(s0_hburst), .s0_hprot(s0_hprot),
    .s0_hmastlock(s0_hmastlock), .s0_hexcl(s0_hexcl), .s0_hwdata(s0_hwdata),
    .s0_hready(s0_hready), .s0_hresp(s0_hresp), .s0_hexokay(s0_hexokay),
    .s0_hrdata(s0_hrdata),
    .s1_haddr(s1_haddr), .s1_hwrite(s1_hwrite), .s1_htrans(s1_htrans),
    .s1_hsize(s1_hsize), .s1_hburst(s1_hburst), .s1_hprot(s1_hprot),
    .s1_hmastlock(s1_hmastlock), .s1_hexcl(s1_hexcl), .s1_hwdata(s1_hwdata),
    .s1_hready(s1_hready), .s1_hresp(s1_hresp), .s1_hexokay(s1_hexokay),
    .s1_hrdata(s1_hrdata),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_htrans(m_htrans),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hprot(m_hprot),
    .m_hmastlock(m_hmastlock), .m_hexcl(m_hexcl), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hexokay(m_hexokay),
    .m_hrdata(m_hrdata), .m_hmaster(m_hmaster)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [IW-1:0] mk(input logic m, input logic [31:0] a,
                                       input logic w, input logic lk,
                                       input logic ex, input logic [2:0] sz);
    return {m, a, w, lk, ex, sz, 2'b10, 3'b000};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drv(input int p, input logic [31:0] a, input logic w,
                     input logic [1:0] t, input logic lk, input logic ex,
                     input logic [2:0] sz, input logic [2:0] bu);
    if (p == 0) begin
      s0_haddr = a; s0_hwrite = w; s0_htrans = t; s0_hmastlock = lk;
      s0_hexcl = ex; s0_hsize = sz; s0_hburst = bu;
    end else begin
      s1_haddr = a; s1_hwrite = w; s1_htrans = t; s1_hmastlock = lk;
      s1_hexcl = ex; s1_hsize = sz; s1_hburst = bu;
    end
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    drv(p, a, 1'b0, 2'b10, 1'b0, 1'b0, 3'd2, 3'b000);
  endtask

  task automatic idle(input int p);
    if (p == 0) begin
      s0_htrans = 2'b00; s0_hmastlock = 1'b0; s0_hexcl = 1'b0;
    end else begin
      s1_htrans = 2'b00; s1_hmastlock = 1'b0; s1_hexcl = 1'b0;
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && m_hready && m_htrans[1]) begin
      mon_got = {m_hmaster, m_haddr, m_hwrite, m_hmastlock, m_hexcl,
                 m_hsize, m_htrans, m_hburst};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue: unexpected transfer got=%h", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL issue: got=%h want=%h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    s0_hprot = 4'b0011; s1_hprot = 4'b0011;
    s0_hwdata = '0; s1_hwdata = '0;
    idle(0); idle(1);
    s0_haddr = '0; s1_haddr = '0; s0_hwrite = 1'b0; s1_hwrite = 1'b0;
    s0_hsize = 3'd2; s1_hsize = 3'd2; s0_hburst = 3'b000; s1_hburst = 3'b000;
    m_hready = 1'b1; m_hresp = 1'b1; m_hexokay = 1'b1; m_hrdata = 32'hDEAD_BEEF;

    // Reset: a live request and an active response must not leak through.
    drv(0, 32'h999, 1'b0, 2'b10, 1'b1, 1'b1, 3'd2, 3'b000);
    mid();
    chk("rst_htrans",    m_htrans, 2'b00);
    chk("rst_hmastlock", m_hmastlock, 0);
    chk("rst_hexcl",     m_hexcl, 0);
    chk("rst_hmaster",   m_hmaster, 0);
    chk("rst_s0_hready", s0_hready, 1);
    chk("rst_s1_hready", s1_hready, 1);
    chk("rst_s0_hresp",  s0_hresp, 0);
    chk("rst_s1_hexokay", s1_hexokay, 0);
    nxt();
    idle(0); m_hresp = 1'b0; m_hexokay = 1'b0; m_hrdata = '0;
    nxt();
    rst_n = 1'b1;

    // Collision in the first cycle after reset: port 0 wins, then port 1.
    rd(0, 32'h10); rd(1, 32'h20);
    exp_q.push_back(mk(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 3'd2));
    exp_q.push_back(mk(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 3'd2));
    mid(); chk("c1_s1_hready", s1_hready, 1);
    nxt(); idle(0); idle(1);
    mid(); chk("c2_s1_hready", s1_hready, 0);
    // Next collision goes back to port 0.
    nxt(); rd(0, 32'h30); rd(1, 32'h34);
    exp_q.push_back(mk(1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 3'd2));
    exp_q.push_back(mk(1'b1, 32'h34, 1'b0, 1'b0, 1'b0, 3'd2));
    mid(); chk("c3_s1_hready", s1_hready, 1);
    nxt(); idle(0); idle(1);
    mid(); chk("c4_s1_hready", s1_hready, 0);
    // No candidate: IDLE with fields held.
    nxt();
    mid();
    chk("idle_htrans",  m_htrans, 2'b00);
    chk("idle_haddr",   m_haddr, 32'h34);
    chk("idle_hmaster", m_hmaster, 1);

    // Lone read from s0, zero added latency, exclusive flag forwarded.
    nxt(); drv(0, 32'h100, 1'b0, 2'b10, 1'b0, 1'b1, 3'd2, 3'b000);
    exp_q.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 3'd2));
    mid(); chk("rd_s1_hready", s1_hready, 1);
    nxt(); idle(0); m_hrdata = 32'h1234_5678; m_hexokay = 1'b1;
    mid();
    chk("rd_s0_hrdata",  s0_hrdata, 32'h1234_5678);
    chk("rd_s1_hrdata",  s1_hrdata, 0);
    chk("rd_s0_hexokay", s0_hexokay, 1);
    chk("rd_s1_hexokay", s1_hexokay, 0);
    chk("rd_s1_hready2", s1_hready, 1);
    nxt(); m_hexokay = 1'b0; m_hrdata = '0;

    // Write from s0 with two wait states, s1 gets buffered meanwhile.
    drv(0, 32'h200, 1'b1, 2'b10, 1'b0, 1'b0, 3'd1, 3'b000);
    exp_q.push_back(mk(1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 3'd1));
    mid();
    nxt(); idle(0); s0_hwdata = 32'hCAFE_F00D; m_hready = 1'b0; rd(1, 32'h300);
    exp_q.push_back(mk(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 3'd2));
    mid();
    chk("wr_w1_hwdata",    m_hwdata, 32'hCAFE_F00D);
    chk("wr_w1_htrans",    m_htrans, 2'b00);
    chk("wr_w1_s0_hready", s0_hready, 0);
    nxt(); idle(1);
    mid();
    chk("wr_w2_hwdata",    m_hwdata, 32'hCAFE_F00D);
    chk("wr_w2_s1_hready", s1_hready, 0);
    chk("wr_w2_htrans",    m_htrans, 2'b00);
    nxt(); m_hready = 1'b1;
    mid();
    chk("wr_done_hwdata",    m_hwdata, 32'hCAFE_F00D);
    chk("wr_done_s0_hready", s0_hready, 1);
    chk("wr_done_haddr",     m_haddr, 32'h300);
    nxt(); s0_hwdata = '0;
    mid();

    // Two-cycle ERROR to s0 while s1 is buffered.
    nxt(); rd(0, 32'h400);
    exp_q.push_back(mk(1'b0, 32'h400, 1'b0, 1'b0, 1'b0, 3'd2));
    mid();
    nxt(); idle(0); m_hresp = 1'b1; m_hready = 1'b0; rd(1, 32'h500);
    exp_q.push_back(mk(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 3'd2));
    mid();
    chk("err1_s0_hresp",  s0_hresp, 1);
    chk("err1_s0_hready", s0_hready, 0);
    chk("err1_s1_hresp",  s1_hresp, 0);
    chk("err1_htrans",    m_htrans, 2'b00);
    nxt(); idle(1); m_hready = 1'b1;
    mid();
    chk("err2_s0_hresp",  s0_hresp, 1);
    chk("err2_s0_hready", s0_hready, 1);
    chk("err2_s1_hresp",  s1_hresp, 0);
    chk("err2_s1_hready", s1_hready, 0);
    chk("err2_haddr",     m_haddr, 32'h500);
    nxt(); m_hresp = 1'b0;
    mid(); chk("err3_s1_hresp", s1_hresp, 0);

    // Locked sequence on s1 while s0 requests; the SEQ beat is re-encoded.
    nxt(); drv(1, 32'h40, 1'b0, 2'b10, 1'b1, 1'b0, 3'd2, 3'b000);
    exp_q.push_back(mk(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 3'd2));
    mid();
    nxt(); rd(0, 32'h80); drv(1, 32'h44, 1'b0, 2'b10, 1'b1, 1'b0, 3'd2, 3'b000);
    exp_q.push_back(mk(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 3'd2));
    mid(); chk("lk_s0_live_hready", s0_hready, 1);
    nxt(); idle(0); drv(1, 32'h48, 1'b0, 2'b11, 1'b1, 1'b0, 3'd2, 3'b011);
    exp_q.push_back(mk(1'b1, 32'h48, 1'b0, 1'b1, 1'b0, 3'd2));
    mid(); chk("lk_s0_wait1", s0_hready, 0);
    nxt(); drv(1, 32'h4C, 1'b0, 2'b10, 1'b0, 1'b0, 3'd2, 3'b000);
    exp_q.push_back(mk(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 3'd2));
    exp_q.push_back(mk(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 3'd2));
    mid(); chk("lk_s0_wait2", s0_hready, 0);
    nxt(); idle(1);
    mid();
    chk("lk_s0_hmaster", m_hmaster, 0);
    chk("lk_s0_haddr",   m_haddr, 32'h80);
    nxt();
    mid();

    // Reset while s1 is buffered: the buffered request is dropped.
    nxt(); m_hready = 1'b0; rd(1, 32'h700);
    mid(); chk("rb_htrans", m_htrans, 2'b00);
    nxt(); idle(1);
    mid(); chk("rb_s1_hready", s1_hready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_rst_s1_hready", s1_hready, 1);
    chk("rb_rst_htrans",    m_htrans, 2'b00);
    nxt(); m_hready = 1'b1; rst_n = 1'b1;
    mid();
    chk("rb_post_htrans",    m_htrans, 2'b00);
    chk("rb_post_s1_hready", s1_hready, 1);
    nxt(); rd(0, 32'h10); rd(1, 32'h20);
    exp_q.push_back(mk(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 3'd2));
    exp_q.push_back(mk(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 3'd2));
    mid(); chk("rb_coll_hmaster", m_hmaster, 0);
    nxt(); idle(0); idle(1);
    mid();
    nxt();
    mid();

    // ---------------- final report ----------------
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
